ipsxe_floating_point_normalize_shift_double_v1_0: RTL and testbench
===================================================================

// Module: ipsxe_floating_point_normalize_shift_double_v1_0
// PURPOSE
//  Consumer of the double-width leading-zero count. Takes the raw 2*(MAN_WIDTH+1)+1-bit product mantissa,
//  its leading-zero count and the pre-normalisation exponent, then left-shifts the mantissa to normalise it.
//  Adjusts the exponent, clamps at the denormal boundary and flags zero/underflow.
//  Sits in the FMA datapath between the zero counter and the rounding stage; 3-stage pipeline gated by i_aclken.
// PARAMETERS
//  MAN_WIDTH      23  stored mantissa width; W = 2*(MAN_WIDTH+1)+1 = datapath width (49 at default)
//  EXP_WIDTH      8   biased exponent width
//  LEADING_0_CNT  6   width of count/shift fields; must satisfy 2**LEADING_0_CNT > W
// PORTS
//  i_clk        in   1                clock, all registers rising-edge
//  i_rst_n      in   1                asynchronous active-low reset
//  i_aclken     in   1                clock enable; low freezes every register (valid included)
//  i_valid      in   1                input beat valid
//  i_m          in   W                unnormalised product mantissa, MSB = bit W-1
//  i_count      in   LEADING_0_CNT    leading zeros of i_m, 0..W (W means i_m==0), cycle-aligned with i_m
//  i_exp        in   EXP_WIDTH+2      signed two's-complement biased exponent before normalisation
//  o_valid      out  1                output beat valid
//  o_m          out  W                normalised mantissa (bit W-1 set unless zero/underflow)
//  o_exp        out  EXP_WIDTH        biased result exponent
//  o_zero       out  1                input mantissa was zero
//  o_underflow  out  1                result denormal: shift clamped, o_exp forced 0
// BEHAVIOUR
//  - Reset (async, i_rst_n=0): all pipeline registers and all outputs = 0 immediately; in-flight beats are discarded.
//  - Latency: exactly 3 enabled cycles (edges with i_aclken=1) from i_valid sample to o_valid. Throughput 1/cycle. No backpressure.
//  - i_aclken=0: no state changes; outputs hold their last values. Beats are neither lost nor duplicated.
//  - Payload registers may load on any enabled edge. o_m/o_exp/flags are meaningful only when o_valid=1.
//  - S0 (decode, registered): compare e=i_exp against c=i_count, using signed EXP_WIDTH+2 arithmetic.
//    * c==W: zero=1, shift=0, exp=0, underflow=0.
//    * else if e-c >= 1: shift=c, exp=e-c, underflow=0.
//    * else (includes e<=0): shift = (e>1) ? e-1 : 0, exp=0, underflow=1.
//      shift < c always holds, so no bits are lost off the top.
//  - S1 (coarse shift, registered): m << {shift[LEADING_0_CNT-1:3],3'b000}, zero-filled from the LSB.
//  - S2 (fine shift, registered to outputs): m << shift[2:0]; also registers exp[EXP_WIDTH-1:0], zero and underflow.
//  - Right-shift denormalisation for e < 1-c is out of scope: such a beat reports underflow=1 with shift 0.
//  - A result exponent >= 2**EXP_WIDTH-1 passes through truncated. Overflow is detected downstream in rounding.
//  - Valid pipe: v0<=i_valid, v1<=v0, o_valid<=v1, each on enabled edges only.
//  - No combinational path from any input to any output.
// TESTING (MAN_WIDTH=23, W=49)
//  T1 i_m=1<<48, c=0, e=127 -> 3 cycles later o_valid=1, o_m=1<<48, o_exp=127, flags 0
//  T2 i_m=1<<40, c=8, e=127 -> o_m=1<<48, o_exp=119, o_underflow=0
//  T3 i_m=0, c=49, e=100 -> o_zero=1, o_m=0, o_exp=0, o_underflow=0
//  T4 i_m=1<<10, c=38, e=5 -> shift 4, o_m=1<<14, o_exp=0, o_underflow=1; repeat with e=-3 -> o_m=1<<10, underflow=1
//  T5 five back-to-back beats, i_aclken pattern 1,0,1,1,0,1.. -> outputs in order, each held while aclken=0, no drops/dups
//  T6 i_rst_n pulsed low while 2 beats are in flight -> o_valid=0 asynchronously; no stale beat emerges after release

Source files
------------

// File: rtl/ipsxe_floating_point_normalize_shift_double_v1_0.sv
// ---------------------------------------------------------------------------
// ipsxe_floating_point_normalize_shift_double_v1_0
//
// Normalising left shifter for the double-width FMA product mantissa.
// It takes the raw product mantissa, its leading-zero count and the
// pre-normalisation exponent. It then:
//   - shifts the mantissa left so that its MSB is set,
//   - lowers the exponent by the shift amount,
//   - clamps the shift at the denormal boundary, so the exponent never goes
//     below 0,
//   - flags zero and underflow results.
//
// Pipeline (every register advances only on edges where i_aclken=1):
//   S0  decode: pick the shift amount, result exponent and flags
//   S1  coarse shift by multiples of 8
//   S2  fine shift by 0..7, registered straight onto the outputs
//
// Parameters
//   MAN_WIDTH      stored mantissa width
//                  W = 2*(MAN_WIDTH+1)+1 is the datapath width
//   EXP_WIDTH      biased exponent width
//   LEADING_0_CNT  width of the count/shift fields; needs 2**LEADING_0_CNT > W
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset; clears every register
//   i_aclken     clock enable; low freezes the whole pipeline
//   i_valid      input beat valid
//   i_m [W]      unnormalised mantissa
//   i_count      leading zeros of i_m (W means i_m == 0)
//   i_exp        signed two's-complement exponent, EXP_WIDTH+2 bits
//   o_valid      output beat valid, 3 enabled cycles after i_valid
//   o_m [W]      normalised mantissa
//   o_exp        biased result exponent, EXP_WIDTH bits
//   o_zero       input mantissa was zero
//   o_underflow  shift was clamped and the exponent forced to 0
// ---------------------------------------------------------------------------
module ipsxe_floating_point_normalize_shift_double_v1_0 #(
   parameter  int MAN_WIDTH     = 23,
   parameter  int EXP_WIDTH     = 8,
   parameter  int LEADING_0_CNT = 6,
   localparam int W             = 2*(MAN_WIDTH+1)+1
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_aclken,
   input  logic                     i_valid,
   input  logic [W-1:0]             i_m,
   input  logic [LEADING_0_CNT-1:0] i_count,
   input  logic [EXP_WIDTH+1:0]     i_exp,
   output logic                     o_valid,
   output logic [W-1:0]             o_m,
   output logic [EXP_WIDTH-1:0]     o_exp,
   output logic                     o_zero,
   output logic                     o_underflow
);

   localparam int EW2 = EXP_WIDTH + 2;
   localparam logic signed [EW2-1:0]       ONE    = EW2'(1);
   localparam logic [LEADING_0_CNT-1:0]    CNT_W  = LEADING_0_CNT'(W);
   // Clears the low three bits of the shift to get the coarse (multiple-of-8) part.
   localparam logic [LEADING_0_CNT-1:0]    COARSE = ~LEADING_0_CNT'(7);

   // Payload carried through S0/S1. The shift amount is still needed here.
   typedef struct packed {
      logic [W-1:0]             m;
      logic [LEADING_0_CNT-1:0] shift;
      logic [EXP_WIDTH-1:0]     exp;
      logic                     zero;
      logic                     uf;
   } stage_t;

   // Output payload. The shift has been fully applied, so it is dropped.
   typedef struct packed {
      logic [W-1:0]         m;
      logic [EXP_WIDTH-1:0] exp;
      logic                 zero;
      logic                 uf;
   } out_t;

   stage_t s0_d, s0_q, s1_d, s1_q;
   out_t   s2_d, s2_q;
   logic [2:0] vld_pipe;

   logic signed [EW2-1:0] e_s, c_s, diff;

   // ---------------- S0: decode ----------------
   always_comb begin
      e_s  = i_exp;
      c_s  = EW2'(i_count);          // count is unsigned; zero-extend
      diff = e_s - c_s;
      s0_d = '0;
      s0_d.m = i_m;
      if (i_count == CNT_W) begin
         // All-zero mantissa: nothing to shift, and the exponent is 0.
         s0_d.zero = 1'b1;
      end else if (diff >= ONE) begin
         // Full normalisation keeps the exponent at 1 or above.
         s0_d.shift = i_count;
         s0_d.exp   = diff[EXP_WIDTH-1:0];
      end else begin
         // Stop the shift where the exponent would reach 1. The result is
         // denormal with exp 0. Since e-1 < c here, no set bit is lost.
         s0_d.uf = 1'b1;
         if (e_s > ONE)
            s0_d.shift = LEADING_0_CNT'(e_s - ONE);
      end
   end

   // ---------------- S1: coarse shift ----------------
   always_comb begin
      s1_d   = s0_q;
      s1_d.m = s0_q.m << (s0_q.shift & COARSE);
   end

   // ---------------- S2: fine shift ----------------
   always_comb begin
      s2_d.m    = s1_q.m << s1_q.shift[2:0];
      s2_d.exp  = s1_q.exp;
      s2_d.zero = s1_q.zero;
      s2_d.uf   = s1_q.uf;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vld_pipe <= '0;
         s0_q     <= '0;
         s1_q     <= '0;
         s2_q     <= '0;
      end else if (i_aclken) begin
         vld_pipe <= {vld_pipe[1:0], i_valid};
         s0_q     <= s0_d;
         s1_q     <= s1_d;
         s2_q     <= s2_d;
      end
   end

   assign o_valid     = vld_pipe[2];
   assign o_m         = s2_q.m;
   assign o_exp       = s2_q.exp;
   assign o_zero      = s2_q.zero;
   assign o_underflow = s2_q.uf;

endmodule

// File: tb/tb_ipsxe_floating_point_normalize_shift_double_v1_0.sv
// Directed-vector bench for the normalising shifter at its default
// parameters (W = 49, exponent 8 bits, count 6 bits).
module tb_ipsxe_floating_point_normalize_shift_double_v1_0;

   localparam int W = 49;

   logic          i_clk, i_rst_n, i_aclken, i_valid;
   logic [W-1:0]  i_m;
   logic [5:0]    i_count;
   logic [9:0]    i_exp;
   logic          o_valid, o_zero, o_underflow;
   logic [W-1:0]  o_m;
   logic [7:0]    o_exp;

   int n_chk  = 0;
   int n_pass = 0;

   ipsxe_floating_point_normalize_shift_double_v1_0 dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_aclken(i_aclken), .i_valid(i_valid),
      .i_m(i_m), .i_count(i_count), .i_exp(i_exp),
      .o_valid(o_valid), .o_m(o_m), .o_exp(o_exp),
      .o_zero(o_zero), .o_underflow(o_underflow)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [W-1:0] bit_at(input int n);
      logic [W-1:0] one;
      one = 1;
      return one << n;
   endfunction

   // Present one beat for one enabled cycle. Return at the negedge that
   // follows the third enabled edge, when the result is on the outputs.
   task automatic send_beat(input logic [W-1:0] m, input logic [5:0] c, input logic [9:0] e);
      @(negedge i_clk);
      i_m = m; i_count = c; i_exp = e; i_valid = 1'b1;
      @(negedge i_clk);
      i_valid = 1'b0;
      @(negedge i_clk);
      @(negedge i_clk);
   endtask

   task automatic chk_out(input string tag, input logic [W-1:0] m, input logic [7:0] e,
                          input logic z, input logic uf);
      chk({tag, "_valid"}, 64'(o_valid), 64'(1));
      chk({tag, "_m"},     64'(o_m), 64'(m));
      chk({tag, "_exp"},   64'(o_exp), 64'(e));
      chk({tag, "_zero"},  64'(o_zero), 64'(z));
      chk({tag, "_uf"},    64'(o_underflow), 64'(uf));
   endtask

   initial begin : stim
      int in_idx, out_idx;
      logic prev_en;
      logic [1:0] snap_v;
      logic [W-1:0] snap_m;
      logic [7:0] snap_e;
      logic [5:0] pat_en;

      i_rst_n = 1'b0; i_aclken = 1'b1; i_valid = 1'b0;
      i_m = '0; i_count = '0; i_exp = '0;
      #1;
      chk("rst_valid", 64'(o_valid), 64'(0));
      chk("rst_m",     64'(o_m), 64'(0));
      chk("rst_exp",   64'(o_exp), 64'(0));
      chk("rst_flags", 64'({o_zero, o_underflow}), 64'(0));
      @(negedge i_clk); @(negedge i_clk);
      i_rst_n = 1'b1;

      // T1: already normalised
      send_beat(bit_at(48), 6'd0, 10'd127);
      chk_out("t1", bit_at(48), 8'd127, 1'b0, 1'b0);
      @(negedge i_clk);
      chk("t1_drop", 64'(o_valid), 64'(0));

      // T2: shift by 8 (coarse shift only)
      send_beat(bit_at(40), 6'd8, 10'd127);
      chk_out("t2", bit_at(48), 8'd119, 1'b0, 1'b0);

      // Shift by 45, which uses both the coarse (40) and fine (5) stages
      send_beat(bit_at(3), 6'd45, 10'd127);
      chk_out("t2b", bit_at(48), 8'd82, 1'b0, 1'b0);

      // T3: zero mantissa
      send_beat('0, 6'd49, 10'd100);
      chk_out("t3", '0, 8'd0, 1'b1, 1'b0);

      // T4: clamped shift, then a negative exponent (no shift)
      send_beat(bit_at(10), 6'd38, 10'd5);
      chk_out("t4a", bit_at(14), 8'd0, 1'b0, 1'b1);
      send_beat(bit_at(10), 6'd38, 10'h3FD);   // e = -3
      chk_out("t4b", bit_at(10), 8'd0, 1'b0, 1'b1);

      // Boundaries: e-c == 1 normalises fully; e-c == 0 clamps to shift c-1
      send_beat(bit_at(40), 6'd8, 10'd9);
      chk_out("edge1", bit_at(48), 8'd1, 1'b0, 1'b0);
      send_beat(bit_at(40), 6'd8, 10'd8);
      chk_out("edge0", bit_at(47), 8'd0, 1'b0, 1'b1);

      // Exponent above 255 comes out truncated: 300 mod 256 = 44
      send_beat(bit_at(48), 6'd0, 10'd300);
      chk_out("trunc", bit_at(48), 8'd44, 1'b0, 1'b0);
      @(negedge i_clk);

      // T5: five beats, clock enable pattern 1,0,1,1,0,1 repeating.
      // Beat j has c = j+1 and e = 100, so it gives o_m = 1<<48, o_exp = 99-j.
      pat_en = 6'b101101;   // bit k%6 is the enable for cycle k
      in_idx = 0; out_idx = 0; prev_en = 1'b0;
      snap_v = '0; snap_m = '0; snap_e = '0;
      for (int k = 0; k < 30; k++) begin
         @(negedge i_clk);
         if (k > 0) begin
            if (prev_en) begin
               if (o_valid) begin
                  chk("t5_extra", 64'(out_idx < 5), 64'(1));
                  chk("t5_m",   64'(o_m), 64'(bit_at(48)));
                  chk("t5_exp", 64'(o_exp), 64'(99 - out_idx));
                  out_idx++;
               end
               if (i_valid) in_idx++;
            end else begin
               chk("t5_hold_v",   64'(o_valid), 64'(snap_v[0]));
               chk("t5_hold_m",   64'(o_m), 64'(snap_m));
               chk("t5_hold_exp", 64'(o_exp), 64'(snap_e));
            end
         end
         snap_v = {1'b0, o_valid}; snap_m = o_m; snap_e = o_exp;
         prev_en  = pat_en[k % 6];
         i_aclken = prev_en;
         if (in_idx < 5) begin
            i_m = bit_at(48 - (in_idx + 1));
            i_count = 6'(in_idx + 1);
            i_exp = 10'd100;
            i_valid = 1'b1;
         end else begin
            i_valid = 1'b0;
         end
      end
      chk("t5_count", 64'(out_idx), 64'(5));
      i_aclken = 1'b1; i_valid = 1'b0;
      @(negedge i_clk); @(negedge i_clk); @(negedge i_clk);

      // T6: reset while beats are in flight
      i_m = bit_at(48); i_count = 6'd0; i_exp = 10'd127; i_valid = 1'b1;
      @(negedge i_clk);
      @(negedge i_clk);
      @(negedge i_clk);
      i_valid = 1'b0;
      chk("t6_pre_valid", 64'(o_valid), 64'(1));
      #1 i_rst_n = 1'b0;
      #1;
      chk("t6_async_valid", 64'(o_valid), 64'(0));
      chk("t6_async_m",     64'(o_m), 64'(0));
      chk("t6_async_exp",   64'(o_exp), 64'(0));
      @(negedge i_clk);
      i_rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge i_clk);
         chk("t6_no_stale", 64'(o_valid), 64'(0));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
